// File: rtl/cmsdk_clock_gate_ctrl_pkg.sv
// Shared definitions for the clock-stop controller: state encoding,
// default dwell parameters and the Moore output decode.
`timescale 1ns/1ps
package cmsdk_clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_REQ     = 2'b01,
    ST_STOPPED = 2'b11,
    ST_WAKE    = 2'b10
  } state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_CNT_WIDTH   = 8;

  // Returns {clkenable, stopreq, gated} for a given state.
  function automatic logic [2:0] decode_outputs(state_e s);
    logic [2:0] o;
    o = 3'b100;
    case (s)
      ST_RUN:     o = 3'b100;
      ST_REQ:     o = 3'b110;
      ST_STOPPED: o = 3'b011;
      ST_WAKE:    o = 3'b100;
      default:    o = 3'b100;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cmsdk_clock_gate_ctrl_cnt.sv
// Clearable up-counter that saturates at TERMINAL and flags terminal count.
`timescale 1ns/1ps
module cmsdk_clock_gate_ctrl_cnt #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 0
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt_q;

  assign tc_o = (cnt_q == TC_VAL);

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cmsdk_clock_gate_ctrl.sv
// Clock-stop controller: idle detection, stop request/acknowledge handshake
// and enable generation for one peripheral clock gate.
`timescale 1ns/1ps
module cmsdk_clock_gate_ctrl
  import cmsdk_clock_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic CLK,
  input  logic RESET,
  input  logic GATEEN,
  input  logic BUSY,
  input  logic WAKEUP,
  input  logic TESTMODE,
  input  logic STOPACK,
  output logic CLKENABLE,
  output logic DISABLEG,
  output logic STOPREQ,
  output logic GATED
);

  state_e state_q, state_d;
  logic   armed_q, armed_d;
  logic   clken_q, stopreq_q, gated_q;
  logic   wk;
  logic   idle_tc, wake_tc;
  logic   go_req;
  logic   idle_clr;
  logic   wake_clr;

  assign wk = BUSY | WAKEUP | ~GATEEN | TESTMODE;

  // Arming requires STOPACK to have been seen low since the last stop, so a
  // stale acknowledge can never complete a fresh request.
  assign go_req   = (state_q == ST_RUN) && !wk && idle_tc && (armed_q || !STOPACK);
  assign idle_clr = (state_q != ST_RUN) || wk || go_req;
  assign wake_clr = (state_q != ST_WAKE);

  cmsdk_clock_gate_ctrl_cnt #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (IDLE_CYCLES - 1)
  ) u_idle_cnt (
    .clk_i  (CLK),
    .srst_i (RESET),
    .clr_i  (idle_clr),
    .inc_i  (!wk),
    .tc_o   (idle_tc)
  );

  cmsdk_clock_gate_ctrl_cnt #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (WAKE_CYCLES - 1)
  ) u_wake_cnt (
    .clk_i  (CLK),
    .srst_i (RESET),
    .clr_i  (wake_clr),
    .inc_i  (1'b1),
    .tc_o   (wake_tc)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    if ((state_q == ST_RUN || state_q == ST_WAKE) && !STOPACK) begin
      armed_d = 1'b1;
    end
    case (state_q)
      ST_RUN: begin
        if (go_req) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wk) begin
          state_d = ST_RUN;
        end else if (STOPACK) begin
          state_d = ST_STOPPED;
          armed_d = 1'b0;
        end
      end
      ST_STOPPED: begin
        if (wk) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_tc && !STOPACK) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_RUN;
      armed_q   <= 1'b0;
      clken_q   <= 1'b1;
      stopreq_q <= 1'b0;
      gated_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      {clken_q, stopreq_q, gated_q} <= decode_outputs(state_d);
    end
  end

  assign CLKENABLE = clken_q;
  assign STOPREQ   = stopreq_q;
  assign GATED     = gated_q;
  assign DISABLEG  = TESTMODE;

endmodule

// File: tb/tb_cmsdk_clock_gate_ctrl.sv
// Directed bench for the clock-stop controller with IDLE_CYCLES=4, WAKE_CYCLES=2.
`timescale 1ns/1ps
module tb_cmsdk_clock_gate_ctrl;

  logic CLK = 1'b0;
  logic RESET, GATEEN, BUSY, WAKEUP, TESTMODE, STOPACK;
  logic CLKENABLE, DISABLEG, STOPREQ, GATED;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cmsdk_clock_gate_ctrl #(
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2),
    .CNT_WIDTH   (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .GATEEN    (GATEEN),
    .BUSY      (BUSY),
    .WAKEUP    (WAKEUP),
    .TESTMODE  (TESTMODE),
    .STOPACK   (STOPACK),
    .CLKENABLE (CLKENABLE),
    .DISABLEG  (DISABLEG),
    .STOPREQ   (STOPREQ),
    .GATED     (GATED)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; GATEEN = 1'b1; BUSY = 1'b0; WAKEUP = 1'b0;
    TESTMODE = 1'b0; STOPACK = 1'b0;
    tick(2);
    checks++; if (CLKENABLE !== 1'b1) begin errors++; $display("FAIL reset_clken got=%b exp=1", CLKENABLE); end
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL reset_stopreq got=%b exp=0", STOPREQ); end
    checks++; if (GATED !== 1'b0) begin errors++; $display("FAIL reset_gated got=%b exp=0", GATED); end
    checks++; if (DISABLEG !== 1'b0) begin errors++; $display("FAIL reset_disableg got=%b exp=0", DISABLEG); end
    RESET = 1'b0;
    tick(3);
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL reset_req_early got=%b exp=0", STOPREQ); end
    tick(1);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL reset_req_at4 got=%b exp=1", STOPREQ); end
    $display("test_reset: STOPREQ=%b after 4 idle cycles", STOPREQ);
  endtask

  task automatic test_full_stop();
    logic bad;
    STOPACK = 1'b1;
    tick(1);
    checks++; if (CLKENABLE !== 1'b0) begin errors++; $display("FAIL stop_clken got=%b exp=0", CLKENABLE); end
    checks++; if (GATED !== 1'b1) begin errors++; $display("FAIL stop_gated got=%b exp=1", GATED); end
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL stop_stopreq got=%b exp=1", STOPREQ); end
    tick(2);
    checks++; if (GATED !== 1'b1) begin errors++; $display("FAIL stop_hold got=%b exp=1", GATED); end
    WAKEUP = 1'b1;
    tick(1);
    checks++; if (CLKENABLE !== 1'b1) begin errors++; $display("FAIL wake_clken got=%b exp=1", CLKENABLE); end
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL wake_stopreq got=%b exp=0", STOPREQ); end
    checks++; if (GATED !== 1'b0) begin errors++; $display("FAIL wake_gated got=%b exp=0", GATED); end
    WAKEUP = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (CLKENABLE !== 1'b1 || STOPREQ !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wake_dwell_outputs got=%b exp=0", bad); end
    STOPACK = 1'b0;
    tick(1);
    tick(3);
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL restart_req_early got=%b exp=0", STOPREQ); end
    tick(1);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL restart_req_at4 got=%b exp=1", STOPREQ); end
    $display("test_full_stop: stop, wake and re-request sequence done");
  endtask

  task automatic test_abort();
    logic bad;
    BUSY = 1'b1; STOPACK = 1'b1;
    tick(1);
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL abort_stopreq got=%b exp=0", STOPREQ); end
    checks++; if (CLKENABLE !== 1'b1) begin errors++; $display("FAIL abort_clken got=%b exp=1", CLKENABLE); end
    BUSY = 1'b0; STOPACK = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (STOPREQ !== 1'b0 || CLKENABLE !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_recount got=%b exp=0", bad); end
    tick(1);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL abort_req_at4 got=%b exp=1", STOPREQ); end
    $display("test_abort: BUSY beat simultaneous STOPACK");
  endtask

  task automatic test_idle_interrupt();
    BUSY = 1'b1;
    tick(1);
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL busy_abort got=%b exp=0", STOPREQ); end
    BUSY = 1'b0;
    tick(2);
    BUSY = 1'b1;
    tick(1);
    BUSY = 1'b0;
    tick(3);
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL interrupt_req_early got=%b exp=0", STOPREQ); end
    tick(1);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL interrupt_req_at4 got=%b exp=1", STOPREQ); end
    $display("test_idle_interrupt: idle count restarted after BUSY");
  endtask

  task automatic test_testmode();
    STOPACK = 1'b1;
    tick(1);
    checks++; if (CLKENABLE !== 1'b0) begin errors++; $display("FAIL tm_stopped_clken got=%b exp=0", CLKENABLE); end
    TESTMODE = 1'b1;
    #1;
    checks++; if (DISABLEG !== 1'b1) begin errors++; $display("FAIL tm_disableg got=%b exp=1", DISABLEG); end
    checks++; if (CLKENABLE !== 1'b0) begin errors++; $display("FAIL tm_same_cycle_clken got=%b exp=0", CLKENABLE); end
    tick(1);
    checks++; if (CLKENABLE !== 1'b1) begin errors++; $display("FAIL tm_wake_clken got=%b exp=1", CLKENABLE); end
    checks++; if (GATED !== 1'b0) begin errors++; $display("FAIL tm_wake_gated got=%b exp=0", GATED); end
    TESTMODE = 1'b0;
    #1;
    checks++; if (DISABLEG !== 1'b0) begin errors++; $display("FAIL tm_disableg_off got=%b exp=0", DISABLEG); end
    STOPACK = 1'b0;
    tick(2);
    $display("test_testmode: DISABLEG followed TESTMODE, woke from STOPPED");
  endtask

  task automatic test_gateen_off();
    logic saw_req, saw_stop;
    GATEEN = 1'b0;
    saw_req = 1'b0; saw_stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (STOPREQ !== 1'b0) saw_req = 1'b1;
      if (CLKENABLE !== 1'b1) saw_stop = 1'b1;
    end
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL gateen_off_stopreq got=%b exp=0", saw_req); end
    checks++; if (saw_stop !== 1'b0) begin errors++; $display("FAIL gateen_off_clken got=%b exp=0", saw_stop); end
    GATEEN = 1'b1;
    $display("test_gateen_off: no request over 20 cycles");
  endtask

  task automatic test_reset_mid_stop();
    logic bad;
    tick(4);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL rms_req got=%b exp=1", STOPREQ); end
    STOPACK = 1'b1;
    tick(1);
    checks++; if (GATED !== 1'b1) begin errors++; $display("FAIL rms_stopped got=%b exp=1", GATED); end
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    checks++; if (CLKENABLE !== 1'b1) begin errors++; $display("FAIL rms_clken got=%b exp=1", CLKENABLE); end
    checks++; if (STOPREQ !== 1'b0) begin errors++; $display("FAIL rms_stopreq got=%b exp=0", STOPREQ); end
    checks++; if (GATED !== 1'b0) begin errors++; $display("FAIL rms_gated got=%b exp=0", GATED); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (CLKENABLE !== 1'b1 || GATED !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rms_stale_ack_stop got=%b exp=0", bad); end
    STOPACK = 1'b0;
    tick(4);
    checks++; if (STOPREQ !== 1'b1) begin errors++; $display("FAIL rms_rearm_req got=%b exp=1", STOPREQ); end
    STOPACK = 1'b1;
    tick(1);
    checks++; if (GATED !== 1'b1) begin errors++; $display("FAIL rms_rearm_gated got=%b exp=1", GATED); end
    checks++; if (CLKENABLE !== 1'b0) begin errors++; $display("FAIL rms_rearm_clken got=%b exp=0", CLKENABLE); end
    $display("test_reset_mid_stop: stale STOPACK held off gating until released");
  endtask

  initial begin
    test_reset();
    test_full_stop();
    test_abort();
    test_idle_interrupt();
    test_testmode();
    test_gateen_off();
    test_reset_mid_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
